// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding, port identifiers and the default acknowledge timeout.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2,
      RESP  = 2'd3
   } arbState_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_rdy;

   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_rdy;

   logic        mem_req;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        bus_err;

   modport slave (
      input  inst_req, inst_addr,
      input  data_req, data_wen, data_addr, data_wdata,
      input  mem_rdata, mem_ack,
      output inst_rdata, inst_rdy,
      output data_rdata, data_rdy,
      output mem_req, mem_wen, mem_addr, mem_wdata,
      output bus_err
   );

   modport master (
      output inst_req, inst_addr,
      output data_req, data_wen, data_addr, data_wdata,
      output mem_rdata, mem_ack,
      input  inst_rdata, inst_rdy,
      input  data_rdata, data_rdy,
      input  mem_req, mem_wen, mem_addr, mem_wdata,
      input  bus_err
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data requesters share one memory port.
// Ties alternate between the ports, a transaction that waits TIMEOUT cycles
// for mem_ack is aborted with bus_err, and all outputs are registered.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   // Last busy cycle index before the abort fires (counter starts at zero).
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   arbState_t   state_r;
   arbState_t   nextState_s;
   logic        pickData_s;
   logic        timeoutHit_s;

   logic        lastGrant_r;
   logic [7:0]  waitCnt_r;
   logic        memReq_r;
   logic [3:0]  memWen_r;
   logic [31:0] memAddr_r;
   logic [31:0] memWdata_r;
   logic [31:0] instRdata_r;
   logic [31:0] dataRdata_r;
   logic        instRdy_r;
   logic        dataRdy_r;
   logic        busErr_r;

   assign timeoutHit_s = (waitCnt_r == TIMEOUT_LAST) && !bus.mem_ack;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state decode, including which port wins the grant in IDLE.
   always_comb begin
      nextState_s = state_r;
      pickData_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.data_req && bus.inst_req) begin
               pickData_s  = (lastGrant_r == PORT_I);
               nextState_s = (lastGrant_r == PORT_I) ? DBUSY : IBUSY;
            end else if (bus.data_req) begin
               pickData_s  = 1'b1;
               nextState_s = DBUSY;
            end else if (bus.inst_req) begin
               pickData_s  = 1'b0;
               nextState_s = IBUSY;
            end else begin
               nextState_s = IDLE;
            end
         end
         IBUSY, DBUSY: begin
            if (bus.mem_ack || timeoutHit_s) begin
               nextState_s = RESP;
            end else begin
               nextState_s = state_r;
            end
         end
         RESP: begin
            nextState_s = IDLE;
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   // Latch the granted request, count wait cycles and build the responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         lastGrant_r <= PORT_I;
         waitCnt_r   <= 8'd0;
         memReq_r    <= 1'b0;
         memWen_r    <= 4'b0000;
         memAddr_r   <= 32'h0000_0000;
         memWdata_r  <= 32'h0000_0000;
         instRdata_r <= 32'h0000_0000;
         dataRdata_r <= 32'h0000_0000;
         instRdy_r   <= 1'b0;
         dataRdy_r   <= 1'b0;
         busErr_r    <= 1'b0;
      end else begin
         memReq_r  <= (nextState_s == IBUSY) || (nextState_s == DBUSY);
         instRdy_r <= 1'b0;
         dataRdy_r <= 1'b0;
         busErr_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (nextState_s != IDLE) begin
                  lastGrant_r <= pickData_s ? PORT_D : PORT_I;
                  waitCnt_r   <= 8'd0;
                  memAddr_r   <= pickData_s ? bus.data_addr : bus.inst_addr;
                  memWen_r    <= pickData_s ? bus.data_wen : 4'b0000;
                  memWdata_r  <= pickData_s ? bus.data_wdata : 32'h0000_0000;
               end
            end
            IBUSY, DBUSY: begin
               if (bus.mem_ack || timeoutHit_s) begin
                  // An aborted transaction returns zero data with bus_err.
                  busErr_r <= !bus.mem_ack;
                  if (state_r == DBUSY) begin
                     dataRdy_r   <= 1'b1;
                     dataRdata_r <= bus.mem_ack ? bus.mem_rdata : 32'h0000_0000;
                  end else begin
                     instRdy_r   <= 1'b1;
                     instRdata_r <= bus.mem_ack ? bus.mem_rdata : 32'h0000_0000;
                  end
               end else begin
                  waitCnt_r <= waitCnt_r + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.mem_req    = memReq_r;
   assign bus.mem_wen    = memWen_r;
   assign bus.mem_addr   = memAddr_r;
   assign bus.mem_wdata  = memWdata_r;
   assign bus.inst_rdata = instRdata_r;
   assign bus.inst_rdy   = instRdy_r;
   assign bus.data_rdata = dataRdata_r;
   assign bus.data_rdy   = dataRdy_r;
   assign bus.bus_err    = busErr_r;

endmodule
